// File: rtl/i2c_register_sequencer_if.sv
// Command/response and I2C-master handshake bundle for i2c_register_sequencer.
// slave = the sequencer, master = the command source plus the I2C master core.
interface i2c_register_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_read;
    logic [6:0] cmd_dev_addr;
    logic [7:0] cmd_reg_addr;
    logic [7:0] cmd_wr_data;
    logic       rsp_valid;
    logic [1:0] rsp_status;
    logic [7:0] rsp_data;
    logic       mode;
    logic       transfer_start;
    logic       transfer_continue;
    logic [7:0] data_tx;
    logic       transfer_ready;
    logic       interrupt;
    logic       ack;
    logic       transaction_complete;
    logic       start_err;
    logic       arbitration_err;
    logic [7:0] data_rx;

    modport slave (
        input  cmd_valid, cmd_read, cmd_dev_addr, cmd_reg_addr, cmd_wr_data,
        output cmd_ready, rsp_valid, rsp_status, rsp_data,
        output mode, transfer_start, transfer_continue, data_tx,
        input  transfer_ready, interrupt, ack, transaction_complete,
        input  start_err, arbitration_err, data_rx
    );

    modport master (
        output cmd_valid, cmd_read, cmd_dev_addr, cmd_reg_addr, cmd_wr_data,
        input  cmd_ready, rsp_valid, rsp_status, rsp_data,
        input  mode, transfer_start, transfer_continue, data_tx,
        output transfer_ready, interrupt, ack, transaction_complete,
        output start_err, arbitration_err, data_rx
    );
endinterface

// File: rtl/i2c_register_sequencer.sv
// Expands one register read/write command into the I2C master byte handshake.
// Define I2C_SEQ_RETRY_EN to retry address NACKs up to MAX_RETRIES times.
module i2c_register_sequencer #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRIES    = 3
) (
    input logic                     clk_in,
    input logic                     reset_n,
    i2c_register_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, STOP_WAIT, RESP} state_t;

    typedef struct packed {
        logic       rd;
        logic [6:0] dev;
        logic [7:0] reg_a;
        logic [7:0] wdata;
    } cmd_t;

    localparam int WDW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t         state_q, state_d;
    cmd_t           cmd_q, cmd_d;
    logic [7:0]     tx_q, tx_d, rdata_q, rdata_d;
    logic [1:0]     stat_q, stat_d;
    logic           mode_q, mode_d, pend_q, pend_d, cont_q, cont_d, retry_q, retry_d;
    logic [WDW-1:0] wd_q;
    logic           err, timeout, can_retry, retry_inc, retry_clr;

`ifdef I2C_SEQ_RETRY_EN
    localparam int RW = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);
    logic [RW-1:0] retry_cnt;

    assign can_retry = (retry_cnt < RW'(MAX_RETRIES));

    always_ff @(posedge clk_in) begin
        if (!reset_n || retry_clr) retry_cnt <= '0;
        else if (retry_inc)        retry_cnt <= retry_cnt + 1'b1;
    end
`else
    logic unused_retry;
    // Without retries the first NACK is final.
    assign can_retry    = (MAX_RETRIES < 0);
    assign unused_retry = retry_inc | retry_clr;
`endif

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        tx_d      = tx_q;
        mode_d    = mode_q;
        pend_d    = pend_q & ~bus.transfer_ready;  // START waits for an idle master
        cont_d    = 1'b0;
        stat_d    = stat_q;
        rdata_d   = rdata_q;
        retry_d   = retry_q;
        retry_inc = 1'b0;
        retry_clr = 1'b0;
        err       = bus.start_err | bus.arbitration_err;
        timeout   = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LAST) &&
                    !bus.interrupt && !bus.transaction_complete;

        if (state_q != IDLE && state_q != RESP && (err || timeout)) begin
            state_d = RESP;
            stat_d  = err ? 2'b10 : 2'b11;
            rdata_d = '0;
            pend_d  = 1'b0;
            retry_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    cmd_d     = '{rd: bus.cmd_read, dev: bus.cmd_dev_addr,
                                  reg_a: bus.cmd_reg_addr, wdata: bus.cmd_wr_data};
                    tx_d      = {bus.cmd_dev_addr, 1'b0};
                    mode_d    = 1'b0;
                    pend_d    = 1'b1;
                    stat_d    = 2'b00;
                    rdata_d   = '0;
                    retry_d   = 1'b0;
                    retry_clr = 1'b1;
                    state_d   = ADDR_W;
                end
                ADDR_W, ADDR_R: if (bus.interrupt) begin
                    if (bus.ack) begin
                        cont_d  = 1'b1;
                        state_d = (state_q == ADDR_W) ? REG : RDATA;
                        if (state_q == ADDR_W) tx_d = cmd_q.reg_a;
                        else                   mode_d = 1'b1;
                    end else begin
                        if (can_retry) retry_d = 1'b1;
                        else           stat_d  = 2'b01;
                        state_d = STOP_WAIT;
                    end
                end
                REG: if (bus.interrupt) begin
                    if (!bus.ack) begin
                        stat_d  = 2'b01;
                        state_d = STOP_WAIT;
                    end else if (cmd_q.rd) begin
                        pend_d  = 1'b1;
                        tx_d    = {cmd_q.dev, 1'b1};
                        state_d = ADDR_R;
                    end else begin
                        cont_d  = 1'b1;
                        tx_d    = cmd_q.wdata;
                        state_d = WDATA;
                    end
                end
                WDATA: if (bus.interrupt) begin
                    stat_d  = bus.ack ? 2'b00 : 2'b01;
                    state_d = STOP_WAIT;
                end
                RDATA: if (bus.interrupt) begin
                    // master NACKs the last read byte, so ack carries no status
                    rdata_d = bus.data_rx;
                    stat_d  = 2'b00;
                    state_d = STOP_WAIT;
                end
                STOP_WAIT: if (bus.transaction_complete) begin
                    if (retry_q) begin
                        retry_d   = 1'b0;
                        retry_inc = 1'b1;
                        tx_d      = {cmd_q.dev, 1'b0};
                        mode_d    = 1'b0;
                        pend_d    = 1'b1;
                        state_d   = ADDR_W;
                    end else begin
                        state_d = RESP;
                    end
                end
                RESP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            tx_q    <= '0;
            mode_q  <= 1'b0;
            pend_q  <= 1'b0;
            cont_q  <= 1'b0;
            stat_q  <= 2'b00;
            rdata_q <= '0;
            retry_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            tx_q    <= tx_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            cont_q  <= cont_d;
            stat_q  <= stat_d;
            rdata_q <= rdata_d;
            retry_q <= retry_d;
            if (state_q == IDLE || state_d != state_q || bus.interrupt || bus.transaction_complete)
                wd_q <= '0;
            else
                wd_q <= wd_q + 1'b1;
        end
    end

    assign bus.cmd_ready         = (state_q == IDLE);
    assign bus.rsp_valid         = (state_q == RESP);
    assign bus.rsp_status        = stat_q;
    assign bus.rsp_data          = rdata_q;
    assign bus.mode              = mode_q;
    assign bus.data_tx           = tx_q;
    assign bus.transfer_continue = cont_q;
    assign bus.transfer_start    = pend_q & bus.transfer_ready;
endmodule

// File: tb/tb_i2c_register_sequencer.sv
// Directed bench for i2c_register_sequencer: a hand-scripted I2C master answers
// each byte; all stimulus driven and outputs sampled on the falling clock edge.
module tb_i2c_register_sequencer;
    logic clk_in  = 1'b0;
    logic reset_n = 1'b0;
    int   n_chk   = 0;
    int   n_bad   = 0;

    i2c_register_sequencer_if bus ();

    i2c_register_sequencer #(.TIMEOUT_CYCLES(100), .MAX_RETRIES(3)) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic rd, input logic [6:0] dev, input logic [7:0] ra,
                            input logic [7:0] wd);
        @(negedge clk_in);
        bus.cmd_valid    = 1'b1;
        bus.cmd_read     = rd;
        bus.cmd_dev_addr = dev;
        bus.cmd_reg_addr = ra;
        bus.cmd_wr_data  = wd;
        @(negedge clk_in);
        bus.cmd_valid = 1'b0;
    endtask

    // One byte on the wire, then sample the decision cycle.
    task automatic serve(input logic a, input logic [7:0] rx, output logic st, output logic ct,
                         output logic [7:0] tx, output logic md);
        repeat (2) @(negedge clk_in);
        bus.interrupt = 1'b1;
        bus.ack       = a;
        bus.data_rx   = rx;
        @(negedge clk_in);
        bus.interrupt = 1'b0;
        bus.ack       = 1'b0;
        st = bus.transfer_start;
        ct = bus.transfer_continue;
        tx = bus.data_tx;
        md = bus.mode;
    endtask

    task automatic stop_done(output logic v, output logic [1:0] s, output logic [7:0] d);
        repeat (2) @(negedge clk_in);
        bus.transaction_complete = 1'b1;
        @(negedge clk_in);
        bus.transaction_complete = 1'b0;
        v = bus.rsp_valid;
        s = bus.rsp_status;
        d = bus.rsp_data;
    endtask

    task automatic write_ok(input logic [6:0] dev, input logic [7:0] ra, input logic [7:0] wd,
                            input logic [7:0] first_byte);
        logic st, ct, md, v;
        logic [7:0] tx, d;
        logic [1:0] s;
        send_cmd(1'b0, dev, ra, wd);
        chk("wr_start", bus.transfer_start, 1);
        chk("wr_addr", bus.data_tx, first_byte);
        chk("wr_busy", bus.cmd_ready, 0);
        serve(1'b1, 8'h00, st, ct, tx, md);
        chk("wr_cont1", {st, ct}, 2'b01);
        chk("wr_reg", tx, ra);
        serve(1'b1, 8'h00, st, ct, tx, md);
        chk("wr_cont2", {st, ct}, 2'b01);
        chk("wr_data", tx, wd);
        serve(1'b1, 8'h00, st, ct, tx, md);
        chk("wr_stop", {st, ct}, 2'b00);
        stop_done(v, s, d);
        chk("wr_rsp", {v, s, d}, {1'b1, 2'b00, 8'h00});
        @(negedge clk_in);
        chk("wr_idle", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    endtask

    initial begin
        #100000;
        $display("FAIL bench_timeout: simulation did not complete");
        $fatal(1, "bench hung");
    end

    initial begin
        logic st, ct, md, v, seen;
        logic [7:0] tx, d;
        logic [1:0] s;
        int n;

        bus.cmd_valid = 0; bus.cmd_read = 0; bus.cmd_dev_addr = 0; bus.cmd_reg_addr = 0;
        bus.cmd_wr_data = 0; bus.transfer_ready = 1; bus.interrupt = 0; bus.ack = 0;
        bus.transaction_complete = 0; bus.start_err = 0; bus.arbitration_err = 0; bus.data_rx = 0;

        repeat (3) @(negedge clk_in);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_status, bus.rsp_data}, 0);
        chk("rst_master", {bus.mode, bus.transfer_start, bus.transfer_continue, bus.data_tx}, 0);
        reset_n = 1'b1;

        // write, all ACK
        write_ok(7'h50, 8'h10, 8'hA5, 8'hA0);

        // read; START held off while the master is busy
        bus.transfer_ready = 1'b0;
        send_cmd(1'b1, 7'h50, 8'h22, 8'h00);
        seen = 1'b0;
        repeat (3) begin
            seen |= bus.transfer_start;
            @(negedge clk_in);
        end
        seen |= bus.transfer_start;
        chk("rd_gate", seen, 0);
        bus.transfer_ready = 1'b1;
        #1;
        chk("rd_start", bus.transfer_start, 1);
        chk("rd_addr", bus.data_tx, 8'hA0);
        serve(1'b1, 8'h00, st, ct, tx, md);
        chk("rd_cont1", {st, ct}, 2'b01);
        chk("rd_reg", tx, 8'h22);
        serve(1'b1, 8'h00, st, ct, tx, md);
        chk("rd_rstart", {st, ct}, 2'b10);
        chk("rd_addr_r", {md, tx}, {1'b0, 8'hA1});
        serve(1'b1, 8'h00, st, ct, tx, md);
        chk("rd_cont2", {st, ct}, 2'b01);
        chk("rd_mode", md, 1);
        serve(1'b0, 8'h3C, st, ct, tx, md);
        chk("rd_stop", {st, ct}, 2'b00);
        stop_done(v, s, d);
        chk("rd_rsp", {v, s, d}, {1'b1, 2'b00, 8'h3C});
        @(negedge clk_in);

        // address NACK
        send_cmd(1'b0, 7'h51, 8'h10, 8'h5A);
        chk("nk_addr", bus.data_tx, 8'hA2);
        serve(1'b0, 8'h00, st, ct, tx, md);
        chk("nk_stop", {st, ct}, 2'b00);
        stop_done(v, s, d);
        chk("nk_rsp", {v, s, d}, {1'b1, 2'b01, 8'h00});
        @(negedge clk_in);

        // arbitration loss while sending the register byte
        send_cmd(1'b0, 7'h50, 8'h33, 8'h77);
        serve(1'b1, 8'h00, st, ct, tx, md);
        chk("ar_cont", {st, ct}, 2'b01);
        @(negedge clk_in);
        bus.arbitration_err = 1'b1;
        @(negedge clk_in);
        bus.arbitration_err = 1'b0;
        chk("ar_rsp", {bus.rsp_valid, bus.rsp_status, bus.rsp_data}, {1'b1, 2'b10, 8'h00});
        @(negedge clk_in);
        chk("ar_idle", {bus.rsp_valid, bus.cmd_ready}, 2'b01);

        // watchdog: master never reports the address byte
        send_cmd(1'b0, 7'h50, 8'h44, 8'h11);
        n = 0;
        while (!bus.rsp_valid && n < 300) begin
            @(negedge clk_in);
            n++;
        end
        chk("to_seen", bus.rsp_valid, 1);
        chk("to_stat", bus.rsp_status, 2'b11);
        chk("to_lat", (n >= 99 && n <= 101), 1);
        @(negedge clk_in);
        chk("to_idle", bus.cmd_ready, 1);

        // reset during the data byte of a write
        send_cmd(1'b0, 7'h50, 8'h55, 8'h66);
        serve(1'b1, 8'h00, st, ct, tx, md);
        serve(1'b1, 8'h00, st, ct, tx, md);
        chk("mr_wdata", {ct, tx}, {1'b1, 8'h66});
        reset_n = 1'b0;
        @(negedge clk_in);
        chk("mr_ready", bus.cmd_ready, 1);
        chk("mr_rsp", {bus.rsp_valid, bus.rsp_status, bus.rsp_data}, 0);
        chk("mr_master", {bus.mode, bus.transfer_start, bus.transfer_continue, bus.data_tx}, 0);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk_in);
            seen |= bus.rsp_valid;
        end
        chk("mr_norsp", seen, 0);
        write_ok(7'h2A, 8'hF0, 8'h0F, 8'h54);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
